// File: rtl/reward_packer.sv
`default_nettype none
// ============================================================================
// Module      : reward_packer
// Description : Picks the next outgoing packet for a node (priority over seven
//               triggers), latches its fields from MY_NODE_INFO, kCH and the
//               neighbour table, and holds them under a valid/ready handshake
//               toward the transmit block. Keeps per-round HB/INV ripple locks
//               and a shared MR/timeslot timeout with latched expiry.
// Ports       : clk, nrst (async active-low)
//               en, tick, roundReset          - control / time base
//               fPacketType, iAmDestination,
//               isCH, sendOwnData             - trigger sources
//               myNodeID..myEnergy            - own node info
//               chosenCH, hopsFromCH          - kCH fields
//               mNode*, mChosenCH, mNodeCHHops - neighbour table fields
//               rReady / rValid, r* fields    - packet handshake
//               reward_done                   - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module reward_packer #(
    parameter int                    WORD_WIDTH  = 16,
    parameter int                    MAX_CH_HOPS = 4,
    parameter int                    MR_TIMEOUT  = 10,
    parameter int                    TS_TIMEOUT  = 10,
    parameter logic [WORD_WIDTH-1:0] BCAST_ID    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  tick,
    input  logic                  roundReset,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic                  isCH,
    input  logic                  sendOwnData,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] hopsFromSink,
    input  logic [WORD_WIDTH-1:0] myQValue,
    input  logic [WORD_WIDTH-1:0] myEnergy,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic [WORD_WIDTH-1:0] mNodeID,
    input  logic [WORD_WIDTH-1:0] mNodeHops,
    input  logic [WORD_WIDTH-1:0] mNodeQValue,
    input  logic [WORD_WIDTH-1:0] mNodeEnergy,
    input  logic [WORD_WIDTH-1:0] mChosenCH,
    input  logic [WORD_WIDTH-1:0] mNodeCHHops,
    input  logic                  rReady,
    output logic                  rValid,
    output logic [WORD_WIDTH-1:0] rSourceID,
    output logic [WORD_WIDTH-1:0] rEnergyLeft,
    output logic [WORD_WIDTH-1:0] rQValue,
    output logic [WORD_WIDTH-1:0] rSourceHops,
    output logic [WORD_WIDTH-1:0] rDestinationID,
    output logic [WORD_WIDTH-1:0] rChosenCH,
    output logic [WORD_WIDTH-1:0] rHopsFromCH,
    output logic [WORD_WIDTH-1:0] rPacketType,
    output logic                  reward_done
);

    // Packet type codes
    localparam logic [2:0] c_type_hb   = 3'd0;
    localparam logic [2:0] c_type_inv  = 3'd2;
    localparam logic [2:0] c_type_mr   = 3'd3;
    localparam logic [2:0] c_type_ts   = 3'd4;
    localparam logic [2:0] c_type_data = 3'd5;

    // FSM states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_pack = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // Trigger selections, listed in priority order
    localparam logic [2:0] c_sel_data_fwd = 3'd0;
    localparam logic [2:0] c_sel_ch_inv   = 3'd1;
    localparam logic [2:0] c_sel_ts       = 3'd2;
    localparam logic [2:0] c_sel_mr       = 3'd3;
    localparam logic [2:0] c_sel_inv_rip  = 3'd4;
    localparam logic [2:0] c_sel_hb       = 3'd5;
    localparam logic [2:0] c_sel_data_own = 3'd6;

    // Timer only needs to hold the larger of the two timeouts
    localparam int c_tmax = (MR_TIMEOUT > TS_TIMEOUT) ? MR_TIMEOUT : TS_TIMEOUT;
    localparam int c_tw   = (c_tmax < 1) ? 1 : $clog2(c_tmax + 1);

    localparam logic [WORD_WIDTH-1:0] c_max_hops = WORD_WIDTH'(MAX_CH_HOPS);
    localparam logic [c_tw-1:0]       c_mr_load  = c_tw'(MR_TIMEOUT);
    localparam logic [c_tw-1:0]       c_ts_load  = c_tw'(TS_TIMEOUT);

    logic [1:0]      r_state;
    logic [2:0]      r_sel;
    logic            r_hb_lock;
    logic            r_inv_lock;
    logic            r_mr_pend;
    logic            r_ts_pend;
    logic            r_timer_type;   // 1 = timeslot timeout, 0 = MR timeout
    logic [c_tw-1:0] r_timer;

    logic                  w_any_trig;
    logic [2:0]            w_sel;
    logic                  w_is_inv;
    logic                  w_is_hb;
    logic                  w_hops_ok;
    logic                  w_pack;
    logic                  w_rx_load;
    logic                  w_load;
    logic                  w_expire;
    logic [2:0]            w_type;
    logic [WORD_WIDTH-1:0] w_dst;
    logic [WORD_WIDTH-1:0] w_ch;
    logic [WORD_WIDTH-1:0] w_hops;

    // These neighbour fields are part of the table interface but never packed
    wire w_unused = ^{mNodeHops, mNodeQValue, mNodeEnergy};

    assign w_is_inv  = (fPacketType == c_type_inv);
    assign w_is_hb   = (fPacketType == c_type_hb);
    assign w_hops_ok = (mNodeCHHops < c_max_hops);
    assign w_pack    = (r_state == c_st_pack);

    // Priority arbitration of the seven triggers
    always_comb begin
        w_any_trig = 1'b1;
        w_sel      = c_sel_data_own;
        if (iAmDestination)                                      w_sel = c_sel_data_fwd;
        else if (isCH && !r_inv_lock)                            w_sel = c_sel_ch_inv;
        else if (r_ts_pend)                                      w_sel = c_sel_ts;
        else if (r_mr_pend)                                      w_sel = c_sel_mr;
        else if (w_is_inv && !isCH && !r_inv_lock && w_hops_ok) w_sel = c_sel_inv_rip;
        else if (w_is_hb && !r_hb_lock)                          w_sel = c_sel_hb;
        else if (sendOwnData)                                    w_sel = c_sel_data_own;
        else                                                     w_any_trig = 1'b0;
    end

    // Per-type fields, built from the inputs present during S_PACK
    always_comb begin
        w_type = c_type_data;
        w_dst  = mNodeID;
        w_ch   = chosenCH;
        w_hops = hopsFromCH;
        case (r_sel)
            c_sel_hb: begin
                w_type = c_type_hb;
                w_dst  = BCAST_ID;
                w_ch   = '0;
                w_hops = '0;
            end
            c_sel_ch_inv: begin
                w_type = c_type_inv;
                w_dst  = BCAST_ID;
                w_ch   = myNodeID;
                w_hops = WORD_WIDTH'(1);
            end
            c_sel_inv_rip: begin
                w_type = c_type_inv;
                w_dst  = BCAST_ID;
                w_ch   = mChosenCH;
                w_hops = mNodeCHHops + WORD_WIDTH'(1);
            end
            c_sel_mr: begin
                w_type = c_type_mr;
                w_dst  = chosenCH;
                w_ch   = chosenCH;
                w_hops = hopsFromCH;
            end
            c_sel_ts: begin
                w_type = c_type_ts;
                w_dst  = BCAST_ID;
                w_ch   = myNodeID;
                w_hops = '0;
            end
            default: begin
                w_type = c_type_data;
                w_dst  = mNodeID;
                w_ch   = chosenCH;
                w_hops = hopsFromCH;
            end
        endcase
    end

    // An out-of-range INV still starts the MR wait, once, if nothing else has
    assign w_rx_load = (r_state == c_st_idle) && en && w_is_inv && !w_hops_ok &&
                       (r_timer == '0) && !r_inv_lock;
    assign w_load    = (w_pack && (r_sel == c_sel_ch_inv || r_sel == c_sel_inv_rip)) ||
                       w_rx_load;
    // A load in the same cycle as a tick suppresses the decrement and expiry
    assign w_expire  = tick && !w_load && (r_timer == c_tw'(1));

    // Round state: locks, pending flags and the shared timeout
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_hb_lock    <= 1'b0;
            r_inv_lock   <= 1'b0;
            r_mr_pend    <= 1'b0;
            r_ts_pend    <= 1'b0;
            r_timer_type <= 1'b0;
            r_timer      <= '0;
        end else if (roundReset) begin
            r_hb_lock  <= 1'b0;
            r_inv_lock <= 1'b0;
            r_mr_pend  <= 1'b0;
            r_ts_pend  <= 1'b0;
            r_timer    <= '0;
        end else begin
            if (w_pack && r_sel == c_sel_hb)
                r_hb_lock <= 1'b1;
            if (w_pack && (r_sel == c_sel_ch_inv || r_sel == c_sel_inv_rip))
                r_inv_lock <= 1'b1;

            if (w_load) begin
                if (w_pack && r_sel == c_sel_ch_inv) begin
                    r_timer      <= c_ts_load;
                    r_timer_type <= 1'b1;
                end else begin
                    r_timer      <= c_mr_load;
                    r_timer_type <= 1'b0;
                end
            end else if (tick && r_timer != '0) begin
                r_timer <= r_timer - c_tw'(1);
            end

            // Clear on consumption first so a coincident expiry is kept
            if (w_pack && r_sel == c_sel_mr) r_mr_pend <= 1'b0;
            if (w_pack && r_sel == c_sel_ts) r_ts_pend <= 1'b0;
            if (w_expire && !r_timer_type)   r_mr_pend <= 1'b1;
            if (w_expire && r_timer_type)    r_ts_pend <= 1'b1;
        end
    end

    // Packet FSM with registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= c_st_idle;
            r_sel          <= c_sel_data_own;
            rValid         <= 1'b0;
            reward_done    <= 1'b0;
            rSourceID      <= '0;
            rEnergyLeft    <= '0;
            rQValue        <= '0;
            rSourceHops    <= '0;
            rDestinationID <= '0;
            rChosenCH      <= '0;
            rHopsFromCH    <= '0;
            rPacketType    <= '0;
        end else begin
            reward_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (en && w_any_trig) begin
                        r_sel   <= w_sel;
                        r_state <= c_st_pack;
                    end
                end
                c_st_pack: begin
                    rSourceID      <= myNodeID;
                    rEnergyLeft    <= myEnergy;
                    rQValue        <= myQValue;
                    rSourceHops    <= hopsFromSink;
                    rDestinationID <= w_dst;
                    rChosenCH      <= w_ch;
                    rHopsFromCH    <= w_hops;
                    rPacketType    <= {{(WORD_WIDTH-3){1'b0}}, w_type};
                    rValid         <= 1'b1;
                    r_state        <= c_st_wait;
                end
                c_st_wait: begin
                    if (rReady) begin
                        rValid      <= 1'b0;
                        reward_done <= 1'b1;
                        r_state     <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reward_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reward_packer
// Description : Directed self-checking bench for reward_packer. Covers reset,
//               HB locking, INV ripple and MR timeout, CH INV and timeslot,
//               trigger priority, handshake stall and reset during S_WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reward_packer;

    localparam int W = 16;

    localparam logic [W-1:0] c_my_id   = 16'h0011;
    localparam logic [W-1:0] c_my_hops = 16'h0002;
    localparam logic [W-1:0] c_my_q    = 16'h0033;
    localparam logic [W-1:0] c_my_en   = 16'h0044;
    localparam logic [W-1:0] c_ch      = 16'h0055;
    localparam logic [W-1:0] c_ch_hops = 16'h0003;
    localparam logic [W-1:0] c_m_id    = 16'h0066;
    localparam logic [W-1:0] c_bcast   = 16'hFFFF;
    localparam logic [2:0]   c_pt_none = 3'd7;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         en = 1'b0, tick = 1'b0, roundReset = 1'b0;
    logic [2:0]   fPacketType = c_pt_none;
    logic         iAmDestination = 1'b0, isCH = 1'b0, sendOwnData = 1'b0;
    logic [W-1:0] mChosenCH = 16'h0007, mNodeCHHops = 16'h0003;
    logic         rReady = 1'b0;
    logic         rValid, reward_done;
    logic [W-1:0] rSourceID, rEnergyLeft, rQValue, rSourceHops;
    logic [W-1:0] rDestinationID, rChosenCH, rHopsFromCH, rPacketType;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int done_base;

    always #5 clk = ~clk;

    always @(negedge clk) if (reward_done === 1'b1) n_done++;

    reward_packer dut (
        .clk(clk), .nrst(nrst), .en(en), .tick(tick), .roundReset(roundReset),
        .fPacketType(fPacketType), .iAmDestination(iAmDestination), .isCH(isCH),
        .sendOwnData(sendOwnData),
        .myNodeID(c_my_id), .hopsFromSink(c_my_hops), .myQValue(c_my_q), .myEnergy(c_my_en),
        .chosenCH(c_ch), .hopsFromCH(c_ch_hops),
        .mNodeID(c_m_id), .mNodeHops(16'h0001), .mNodeQValue(16'h0077),
        .mNodeEnergy(16'h0088), .mChosenCH(mChosenCH), .mNodeCHHops(mNodeCHHops),
        .rReady(rReady), .rValid(rValid),
        .rSourceID(rSourceID), .rEnergyLeft(rEnergyLeft), .rQValue(rQValue),
        .rSourceHops(rSourceHops), .rDestinationID(rDestinationID),
        .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH),
        .rPacketType(rPacketType), .reward_done(reward_done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic round_reset();
        roundReset = 1'b1;
        step();
        roundReset = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    // Pulse en and expect no packet to start
    task automatic no_pkt(input string tag);
        en = 1'b1;
        step();
        en = 1'b0;
        step();
        step();
        check_val(tag, {31'd0, rValid}, 32'd0);
    endtask

    // Pulse en, expect one packet with the given fields, stall rReady, then complete
    task automatic run_pkt(input string tag, input logic [W-1:0] e_type,
                           input logic [W-1:0] e_dst, input logic [W-1:0] e_ch,
                           input logic [W-1:0] e_hops, input int stall, input bit tick_stall);
        int k;
        en = 1'b1;
        step();
        en = 1'b0;
        k = 0;
        while (rValid !== 1'b1 && k < 6) begin
            step();
            k++;
        end
        check_val({tag, "_valid"},   {31'd0, rValid}, 32'd1);
        check_val({tag, "_latency"}, k,               32'd1);
        check_val({tag, "_type"},    rPacketType,     e_type);
        check_val({tag, "_dst"},     rDestinationID,  e_dst);
        check_val({tag, "_ch"},      rChosenCH,       e_ch);
        check_val({tag, "_hops"},    rHopsFromCH,     e_hops);
        check_val({tag, "_src"},     rSourceID,       c_my_id);
        check_val({tag, "_energy"},  rEnergyLeft,     c_my_en);
        check_val({tag, "_q"},       rQValue,         c_my_q);
        check_val({tag, "_shops"},   rSourceHops,     c_my_hops);
        tick = tick_stall;
        for (int i = 0; i < stall; i++) begin
            step();
            check_val({tag, "_stall_valid"}, {31'd0, rValid}, 32'd1);
            check_val({tag, "_stall_dst"},   rDestinationID,  e_dst);
            check_val({tag, "_stall_hops"},  rHopsFromCH,     e_hops);
            check_val({tag, "_stall_done"},  {31'd0, reward_done}, 32'd0);
        end
        tick = 1'b0;
        rReady = 1'b1;
        step();
        rReady = 1'b0;
        check_val({tag, "_done"},      {31'd0, reward_done}, 32'd1);
        check_val({tag, "_valid_off"}, {31'd0, rValid},      32'd0);
        step();
        check_val({tag, "_done_off"},  {31'd0, reward_done}, 32'd0);
    endtask

    initial begin
        // Power-on reset
        #12;
        check_val("rst_valid", {31'd0, rValid},      32'd0);
        check_val("rst_done",  {31'd0, reward_done}, 32'd0);
        check_val("rst_dst",   rDestinationID,       32'd0);
        check_val("rst_type",  rPacketType,          32'd0);
        @(negedge clk) nrst = 1'b1;
        step();

        // HB ripple, 5-cycle stall, lock, re-arm after roundReset
        fPacketType = 3'd0;
        run_pkt("hb1", 16'd0, c_bcast, 16'd0, 16'd0, 5, 1'b0);
        no_pkt("hb_locked");
        round_reset();
        run_pkt("hb2", 16'd0, c_bcast, 16'd0, 16'd0, 0, 1'b0);
        fPacketType = c_pt_none;
        round_reset();

        // INV ripple, then MR after exactly MR_TIMEOUT ticks
        fPacketType = 3'd2;
        mNodeCHHops = 16'd3;
        mChosenCH   = 16'd7;
        run_pkt("inv_rip", 16'd2, c_bcast, 16'd7, 16'd4, 0, 1'b0);
        fPacketType = c_pt_none;
        ticks(9);
        no_pkt("mr_early");
        ticks(1);
        run_pkt("mr1", 16'd3, c_ch, c_ch, c_ch_hops, 0, 1'b0);
        no_pkt("mr_consumed");

        // INV at the hop limit: no ripple, but the MR wait still starts
        round_reset();
        fPacketType = 3'd2;
        mNodeCHHops = 16'd4;
        no_pkt("inv_max");
        fPacketType = c_pt_none;
        ticks(10);
        run_pkt("mr2", 16'd3, c_ch, c_ch, c_ch_hops, 0, 1'b0);

        // CH INV, then timeslot expiry while stalled in S_WAIT
        round_reset();
        mNodeCHHops = 16'd3;
        isCH = 1'b1;
        run_pkt("ch_inv", 16'd2, c_bcast, c_my_id, 16'd1, 0, 1'b0);
        sendOwnData = 1'b1;
        run_pkt("own_stall", 16'd5, c_m_id, c_ch, c_ch_hops, 10, 1'b1);
        run_pkt("ts", 16'd4, c_bcast, c_my_id, 16'd0, 0, 1'b0);
        sendOwnData = 1'b0;
        isCH = 1'b0;

        // Priority: DATA forward, then HB, then own DATA
        round_reset();
        done_base = n_done;
        iAmDestination = 1'b1;
        sendOwnData    = 1'b1;
        fPacketType    = 3'd0;
        run_pkt("prio_fwd", 16'd5, c_m_id, c_ch, c_ch_hops, 0, 1'b0);
        iAmDestination = 1'b0;
        run_pkt("prio_hb", 16'd0, c_bcast, 16'd0, 16'd0, 0, 1'b0);
        run_pkt("prio_own", 16'd5, c_m_id, c_ch, c_ch_hops, 0, 1'b0);
        check_val("prio_pulses", n_done - done_base, 32'd3);
        fPacketType = c_pt_none;

        // Reset asserted while waiting for rReady
        en = 1'b1;
        step();
        en = 1'b0;
        step();
        check_val("mid_pre_valid", {31'd0, rValid}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        check_val("mid_valid", {31'd0, rValid}, 32'd0);
        check_val("mid_src",   rSourceID,       32'd0);
        check_val("mid_dst",   rDestinationID,  32'd0);
        check_val("mid_ch",    rChosenCH,       32'd0);
        check_val("mid_hops",  rHopsFromCH,     32'd0);
        done_base = n_done;
        @(negedge clk) nrst = 1'b1;
        rReady = 1'b1;
        repeat (3) step();
        rReady = 1'b0;
        check_val("mid_no_done", n_done - done_base, 32'd0);
        check_val("mid_idle_valid", {31'd0, rValid}, 32'd0);
        run_pkt("post_rst", 16'd5, c_m_id, c_ch, c_ch_hops, 0, 1'b0);
        sendOwnData = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors %0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
